gcm_counter_dispatch: RTL and testbench
=======================================

GCM_COUNTER_DISPATCH -- requirements
Module: gcm_counter_dispatch

Interface
REQ-001 Parameter NUM_WORKERS, default 4, number of parallel AES workers (1..8); lane width LANE_W = max(1, clog2(NUM_WORKERS)).
REQ-002 Parameter LEN_W, default 64, width of the AAD and text bit-length inputs.
REQ-003 clk  in  1  sole clock; all logic is rising-edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 i_start  in  1  start a new instance; qualified by o_start_ready.
REQ-006 i_iv  in  96  instance IV.
REQ-007 i_aad_bits  in  LEN_W  AAD length in bits.
REQ-008 i_text_bits  in  LEN_W  text length in bits.
REQ-009 i_flush  in  1  abort the current instance.
REQ-010 i_ready  in  1  downstream accepts the current beat.
REQ-011 o_start_ready  out  1  high only in IDLE.
REQ-012 o_valid  out  1  beat valid.
REQ-013 o_phase  out  3  beat phase, encoded per REQ-019.
REQ-014 o_counter  out  32  beat index within the instance.
REQ-015 o_ctr_block  out  128  counter block: IV followed by the 32-bit counter.
REQ-016 o_lane  out  LANE_W  target worker.
REQ-017 o_last  out  1  final beat of the instance.
REQ-018 o_len_err  out  1  one-cycle pulse when a start is rejected.

Function
REQ-019 Phase codes: AAD 010; first text 000; middle text 001; last text 011; single text block 111; tag J0 101; idle 100.
REQ-020 Block counts use ceiling division: A = ceil(aad_bits/128) and T = ceil(text_bits/128).
REQ-021 Start is accepted when i_start and o_start_ready are both high; the first beat has o_valid high on the next cycle.
REQ-022 States: IDLE, AAD, TEXT, J0.
  - From IDLE, go to AAD if A>0, else TEXT if T>0, else J0 (or IDLE with no beat when J0 is compiled out).
REQ-023 AAD beats: o_counter runs 0..A-1; o_ctr_block is all zeros.
REQ-024 Text beat k: o_counter = A+k; o_ctr_block = IV followed by 32-bit value k+2.
REQ-025 A beat advances only on o_valid and i_ready; while o_valid is high and i_ready is low, every output is held stable.
REQ-026 o_lane = (beat index mod NUM_WORKERS); the index counts all beats of the instance, including J0.
REQ-027 o_last is high on the final beat; after that beat is accepted, the block returns to IDLE and o_start_ready rises on the next cycle.
REQ-028 If text_bits > 2^39-256, or aad_bits >= 2^64, the start is rejected: o_len_err pulses, the state stays IDLE, and no beat is emitted.
REQ-029 i_start while busy is ignored.
REQ-030 i_flush has priority over i_ready: on the next cycle o_valid=0 and the state is IDLE; a flush in IDLE has no effect.
REQ-031 The 32-bit counter increment wraps modulo 2^32; REQ-028 prevents wrap in legal use.

Reset
REQ-032 Reset, asserted at any time including mid-instance, forces the following on the next edge:
  - state IDLE;
  - o_valid=0, o_phase=100, o_counter=0, o_ctr_block=0, o_lane=0, o_last=0, o_len_err=0, o_start_ready=1.
REQ-033 Reset takes priority over i_flush and i_start.

Configuration
REQ-034 Macro GCM_TAG_J0_EN:
  - Defined: after the last text beat (or directly when T=0), one J0 beat is emitted with phase 101, o_ctr_block = IV followed by 32'd1, o_counter = A+T, and o_last=1.
  - Undefined: the J0 state is absent, and o_last is on the last text beat, or on the last AAD beat when T=0.

Structure
REQ-035 Package gcm_pkg holds:
  - the phase enum typedef (REQ-019);
  - the state enum;
  - constants GCM_BLOCK_BITS=128 and GCM_MAX_TEXT_BITS=2^39-256.
REQ-036 One sub-module, gcm_inc32, computes IV concatenated with (x+2) and IV concatenated with 1; all other logic stays in gcm_counter_dispatch.

Verification
REQ-037 NUM_WORKERS=4, aad=256, text=384, i_ready=1 -> phases 010,010,000,001,011, then 101 (with macro); counters 0..5; text ctr tails 2,3,4; lanes 0,1,2,3,0,1.
REQ-038 aad=0, text=100 -> single beat: phase 111, ctr tail 2, counter 0; o_last on this beat without the macro.
REQ-039 i_ready low for 3 cycles on the beat with counter 2 -> all outputs held identical; the beat then advances once i_ready rises.
REQ-040 i_flush at beat 3 of a 10-beat instance -> o_valid=0 and o_start_ready=1 on the next cycle; a following start begins at counter 0 and lane 0.
REQ-041 text = 2^39 -> o_len_err pulses for one cycle and no beat is emitted; rst asserted mid-instance -> all reset values of REQ-032 on the next edge.
REQ-042 NUM_WORKERS=1 and NUM_WORKERS=3, text=640 -> o_lane is always 0 for 1 worker, and runs 0,1,2,0,1 for 3 workers.

Source files
------------

// File: rtl/gcm_pkg.sv
// Shared types and constants for the GCM counter dispatcher: beat phase codes,
// dispatcher states and the length limits that decide whether a start is accepted.
package gcm_pkg;

    localparam int          GCM_BLOCK_BITS    = 128;
    // 2^39 - 256: the largest text length GCM allows.
    localparam logic [63:0] GCM_MAX_TEXT_BITS = 64'h0000_007F_FFFF_FF00;

    typedef enum logic [2:0] {
        PH_FIRST  = 3'b000,
        PH_MID    = 3'b001,
        PH_AAD    = 3'b010,
        PH_LAST   = 3'b011,
        PH_IDLE   = 3'b100,
        PH_J0     = 3'b101,
        PH_SINGLE = 3'b111
    } phase_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AAD,
        ST_TEXT,
        ST_J0
    } state_e;

endpackage

// File: rtl/gcm_inc32.sv
// Builds GCM counter blocks: IV || (x + 2) for text beats and IV || 1 for the tag J0 block.
module gcm_inc32 (
    input  logic [95:0]  iv,
    input  logic [31:0]  x,
    output logic [127:0] ctr_block,
    output logic [127:0] j0_block
);

    // The 32-bit add wraps modulo 2^32, which is the GCM inc32 behaviour.
    assign ctr_block = {iv, x + 32'd2};
    assign j0_block  = {iv, 32'd1};

endmodule

// File: rtl/gcm_counter_dispatch.sv
// Issues one beat per AAD block, text block and (with GCM_TAG_J0_EN defined) a final
// tag J0 block, spreading the beats round-robin across NUM_WORKERS AES lanes.
module gcm_counter_dispatch
    import gcm_pkg::*;
#(
    parameter  int NUM_WORKERS = 4,
    parameter  int LEN_W       = 64,
    localparam int LANE_W      = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [95:0]       i_iv,
    input  logic [LEN_W-1:0]  i_aad_bits,
    input  logic [LEN_W-1:0]  i_text_bits,
    input  logic              i_flush,
    input  logic              i_ready,
    output logic              o_start_ready,
    output logic              o_valid,
    output logic [2:0]        o_phase,
    output logic [31:0]       o_counter,
    output logic [127:0]      o_ctr_block,
    output logic [LANE_W-1:0] o_lane,
    output logic              o_last,
    output logic              o_len_err
);

    localparam int EXT_W = (LEN_W > 64) ? LEN_W : 64;
    localparam int BLK_SHIFT = $clog2(GCM_BLOCK_BITS);

    state_e             state_q, state_d, after_text;
    logic [95:0]        iv_q, iv_d;
    logic [EXT_W-1:0]   a_q, a_d, t_q, t_d, sub_q, sub_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [LANE_W-1:0]  lane_q, lane_d;
    logic               len_err_q, len_err_d;

    logic [EXT_W:0]     aad_ext;
    logic [EXT_W-1:0]   text_ext, a_blocks, t_blocks;
    logic               len_bad, aad_end, text_end, accept;
    logic [127:0]       text_block, j0_block;

    assign aad_ext  = (EXT_W + 1)'(i_aad_bits);
    assign text_ext = EXT_W'(i_text_bits);
    assign len_bad  = (|(aad_ext >> 64)) || (text_ext > EXT_W'(GCM_MAX_TEXT_BITS));
    assign a_blocks = (aad_ext[EXT_W-1:0] >> BLK_SHIFT) + EXT_W'(|aad_ext[BLK_SHIFT-1:0]);
    assign t_blocks = (text_ext >> BLK_SHIFT) + EXT_W'(|text_ext[BLK_SHIFT-1:0]);

    assign aad_end  = (sub_q == a_q - EXT_W'(1));
    assign text_end = (sub_q == t_q - EXT_W'(1));
    assign accept   = o_valid && i_ready;

`ifdef GCM_TAG_J0_EN
    assign after_text = ST_J0;
`else
    assign after_text = ST_IDLE;
`endif

    gcm_inc32 u_inc32 (
        .iv        (iv_q),
        .x         (sub_q[31:0]),
        .ctr_block (text_block),
        .j0_block  (j0_block)
    );

    always_comb begin
        // NOTE: every next-state variable gets its hold value first so no path infers a latch.
        state_d   = state_q;
        iv_d      = iv_q;
        a_d       = a_q;
        t_d       = t_q;
        sub_d     = sub_q;
        cnt_d     = cnt_q;
        lane_d    = lane_q;
        len_err_d = 1'b0;

        if (state_q == ST_IDLE) begin
            if (i_start) begin
                if (len_bad) begin
                    len_err_d = 1'b1;
                end else begin
                    iv_d  = i_iv;
                    a_d   = a_blocks;
                    t_d   = t_blocks;
                    sub_d = '0;
                    cnt_d = '0;
                    lane_d = '0;
                    if (a_blocks != '0)      state_d = ST_AAD;
                    else if (t_blocks != '0) state_d = ST_TEXT;
                    else                     state_d = after_text;
                end
            end
        end else if (i_flush) begin
            state_d = ST_IDLE;
        end else if (accept) begin
            cnt_d  = cnt_q + 32'd1;
            lane_d = (lane_q == LANE_W'(NUM_WORKERS - 1)) ? '0 : lane_q + LANE_W'(1);
            sub_d  = sub_q + EXT_W'(1);
            case (state_q)
                ST_AAD: if (aad_end) begin
                    sub_d   = '0;
                    state_d = (t_q != '0) ? ST_TEXT : after_text;
                end
                ST_TEXT: if (text_end) state_d = after_text;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (rst) begin
            state_q   <= ST_IDLE;
            iv_q      <= '0;
            a_q       <= '0;
            t_q       <= '0;
            sub_q     <= '0;
            cnt_q     <= '0;
            lane_q    <= '0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            iv_q      <= iv_d;
            a_q       <= a_d;
            t_q       <= t_d;
            sub_q     <= sub_d;
            cnt_q     <= cnt_d;
            lane_q    <= lane_d;
            len_err_q <= len_err_d;
        end
    end

    // Outputs are decoded from flops only, so a stalled beat stays bit-stable.
    always_comb begin
        o_start_ready = (state_q == ST_IDLE);
        o_valid       = (state_q != ST_IDLE);
        o_len_err     = len_err_q;
        o_counter     = o_valid ? cnt_q : 32'd0;
        o_lane        = o_valid ? lane_q : '0;
        o_phase       = PH_IDLE;
        o_ctr_block   = '0;
        case (state_q)
            ST_AAD: o_phase = PH_AAD;
            ST_TEXT: begin
                o_ctr_block = text_block;
                if (t_q == EXT_W'(1))    o_phase = PH_SINGLE;
                else if (sub_q == '0)    o_phase = PH_FIRST;
                else if (text_end)       o_phase = PH_LAST;
                else                     o_phase = PH_MID;
            end
            ST_J0: begin
                o_phase     = PH_J0;
                o_ctr_block = j0_block;
            end
            default: ;
        endcase
`ifdef GCM_TAG_J0_EN
        o_last = (state_q == ST_J0);
`else
        o_last = ((state_q == ST_TEXT) && text_end) ||
                 ((state_q == ST_AAD) && aad_end && (t_q == '0));
`endif
    end

endmodule

// File: tb/tb_gcm_counter_dispatch.sv
// Directed bench for gcm_counter_dispatch: a vector table of instance lengths plus
// hand-written stall, flush, length-error, reset and lane sequences.
module tb_gcm_counter_dispatch;

`ifdef GCM_TAG_J0_EN
    localparam int J0 = 1;
`else
    localparam int J0 = 0;
`endif

    logic         clk = 1'b0;
    logic         rst, i_start, i_flush, i_ready;
    logic [95:0]  i_iv;
    logic [63:0]  i_aad_bits, i_text_bits;

    logic         sr4, v4, last4, le4;
    logic [2:0]   ph4;
    logic [31:0]  cnt4;
    logic [127:0] blk4;
    logic [1:0]   lane4;

    logic         sr1, v1, last1, le1;
    logic [2:0]   ph1;
    logic [31:0]  cnt1;
    logic [127:0] blk1;
    logic [0:0]   lane1;

    logic         sr3, v3, last3, le3;
    logic [2:0]   ph3;
    logic [31:0]  cnt3;
    logic [127:0] blk3;
    logic [1:0]   lane3;

    int n_checks = 0;
    int n_bad    = 0;

    always #5 clk = ~clk;

    gcm_counter_dispatch #(.NUM_WORKERS(4), .LEN_W(64)) u4 (
        .clk(clk), .rst(rst), .i_start(i_start), .i_iv(i_iv), .i_aad_bits(i_aad_bits),
        .i_text_bits(i_text_bits), .i_flush(i_flush), .i_ready(i_ready),
        .o_start_ready(sr4), .o_valid(v4), .o_phase(ph4), .o_counter(cnt4),
        .o_ctr_block(blk4), .o_lane(lane4), .o_last(last4), .o_len_err(le4));

    gcm_counter_dispatch #(.NUM_WORKERS(1), .LEN_W(64)) u1 (
        .clk(clk), .rst(rst), .i_start(i_start), .i_iv(i_iv), .i_aad_bits(i_aad_bits),
        .i_text_bits(i_text_bits), .i_flush(i_flush), .i_ready(i_ready),
        .o_start_ready(sr1), .o_valid(v1), .o_phase(ph1), .o_counter(cnt1),
        .o_ctr_block(blk1), .o_lane(lane1), .o_last(last1), .o_len_err(le1));

    gcm_counter_dispatch #(.NUM_WORKERS(3), .LEN_W(64)) u3 (
        .clk(clk), .rst(rst), .i_start(i_start), .i_iv(i_iv), .i_aad_bits(i_aad_bits),
        .i_text_bits(i_text_bits), .i_flush(i_flush), .i_ready(i_ready),
        .o_start_ready(sr3), .o_valid(v3), .o_phase(ph3), .o_counter(cnt3),
        .o_ctr_block(blk3), .o_lane(lane3), .o_last(last3), .o_len_err(le3));

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [63:0] aad, input logic [63:0] text, input logic [95:0] iv);
        i_aad_bits  = aad;
        i_text_bits = text;
        i_iv        = iv;
        i_start     = 1'b1;
        step();
        i_start     = 1'b0;
    endtask

    // zero_blk selects an all-zero counter block (AAD beats); otherwise IV || tail.
    task automatic chk_beat(input string tag, input logic [2:0] ph, input int cnt,
                            input logic [31:0] tail, input int lane, input logic last,
                            input logic zero_blk);
        check({tag, ".valid"}, v4, 1'b1);
        check({tag, ".phase"}, ph4, ph);
        check({tag, ".counter"}, cnt4, cnt);
        check({tag, ".lane"}, lane4, lane);
        check({tag, ".last"}, last4, last);
        check({tag, ".block"}, blk4, zero_blk ? 128'd0 : {i_iv, tail});
    endtask

    typedef struct {
        logic [63:0] aad;
        logic [63:0] text;
        int          a;
        int          t;
    } vec_t;

    vec_t tab[7];

    initial begin
        logic [2:0]   s_ph;
        logic [31:0]  s_cnt;
        logic [127:0] s_blk;
        logic [1:0]   s_lane;
        logic         s_last;
        logic [2:0]   ph_seq[6];
        int           lane3_seq[5];

        // Hand-computed ceil(bits/128) block counts.
        tab[0] = '{64'd0,   64'd1,   0, 1};
        tab[1] = '{64'd128, 64'd128, 1, 1};
        tab[2] = '{64'd129, 64'd0,   2, 0};
        tab[3] = '{64'd0,   64'd256, 0, 2};
        tab[4] = '{64'd1,   64'd129, 1, 2};
        tab[5] = '{64'd300, 64'd500, 3, 4};
        tab[6] = '{64'd0,   64'd0,   0, 0};

        rst = 1'b1; i_start = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
        i_iv = '0; i_aad_bits = '0; i_text_bits = '0;
        step(); step();
        rst = 1'b0;
        check("rst.valid", v4, 1'b0);
        check("rst.start_ready", sr4, 1'b1);
        check("rst.phase", ph4, 3'b100);
        check("rst.counter", cnt4, 0);

        // aad=256, text=384 with all lanes of a 4-worker build.
        ph_seq = '{3'b010, 3'b010, 3'b000, 3'b001, 3'b011, 3'b101};
        do_start(64'd256, 64'd384, 96'hA1A2A3A4_B1B2B3B4_C1C2C3C4);
        for (int k = 0; k < 5 + J0; k++) begin
            chk_beat($sformatf("seq37.b%0d", k), ph_seq[k], k,
                     (k < 2) ? 32'd0 : ((k == 5) ? 32'd1 : 32'(k)), k % 4,
                     k == 4 + J0, k < 2);
            step();
        end
        check("seq37.idle_after", sr4, 1'b1);

        // aad=0, text=100: one single-block beat.
        do_start(64'd0, 64'd100, 96'h1234);
        chk_beat("seq38.b0", 3'b111, 0, 32'd2, 0, J0 == 0, 1'b0);
        step();
        if (J0 == 1) begin
            chk_beat("seq38.j0", 3'b101, 1, 32'd1, 1, 1'b1, 1'b0);
            step();
        end
        check("seq38.idle_after", sr4, 1'b1);

        // Table vectors, full-rate acceptance.
        for (int v = 0; v < 7; v++) begin
            int nb;
            nb = tab[v].a + tab[v].t + J0;
            do_start(tab[v].aad, tab[v].text, {32'hC0DE0000 + 32'(v), 64'h0123_4567_89AB_CDEF});
            if (nb == 0) check($sformatf("tab%0d.no_beat", v), v4, 1'b0);
            for (int k = 0; k < nb; k++) begin
                logic [2:0]  eph;
                logic [31:0] etail;
                int          j;
                j = k - tab[v].a;
                if (k < tab[v].a) begin
                    eph = 3'b010; etail = 32'd0;
                end else if (j < tab[v].t) begin
                    etail = 32'(j + 2);
                    if (tab[v].t == 1)           eph = 3'b111;
                    else if (j == 0)             eph = 3'b000;
                    else if (j == tab[v].t - 1)  eph = 3'b011;
                    else                         eph = 3'b001;
                end else begin
                    eph = 3'b101; etail = 32'd1;
                end
                chk_beat($sformatf("tab%0d.b%0d", v, k), eph, k, etail, k % 4,
                         k == nb - 1, k < tab[v].a);
                step();
            end
            check($sformatf("tab%0d.idle_after", v), sr4, 1'b1);
        end

        // Stall on the beat with counter 2; i_start while busy must be ignored.
        do_start(64'd0, 64'd640, 96'h5555);
        step(); step();
        i_ready = 1'b0;
        i_start = 1'b1;
        s_ph = ph4; s_cnt = cnt4; s_blk = blk4; s_lane = lane4; s_last = last4;
        check("stall.counter", s_cnt, 32'd2);
        for (int c = 0; c < 3; c++) begin
            step();
            check("stall.valid", v4, 1'b1);
            check("stall.phase", ph4, s_ph);
            check("stall.counter_hold", cnt4, s_cnt);
            check("stall.block", blk4, s_blk);
            check("stall.lane", lane4, s_lane);
            check("stall.last", last4, s_last);
        end
        i_start = 1'b0;
        i_ready = 1'b1;
        step();
        chk_beat("stall.resume", 3'b001, 3, 32'd5, 3, 1'b0, 1'b0);
        step(); step();
        if (J0 == 1) step();
        check("stall.idle_after", sr4, 1'b1);

        // Flush at beat 3 of a 10-beat instance, with i_ready high.
        do_start(64'd0, 64'd1280, 96'h7777);
        step(); step(); step();
        check("flush.at_beat3", cnt4, 32'd3);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        check("flush.valid", v4, 1'b0);
        check("flush.start_ready", sr4, 1'b1);
        do_start(64'd128, 64'd0, 96'h8888);
        chk_beat("flush.restart", 3'b010, 0, 32'd0, 0, J0 == 0, 1'b1);
        step();
        if (J0 == 1) step();

        // Length limits: 2^39 is rejected, 2^39-256 is accepted.
        do_start(64'd0, 64'h0000_0080_0000_0000, 96'h9999);
        check("lenerr.pulse", le4, 1'b1);
        check("lenerr.no_beat", v4, 1'b0);
        check("lenerr.start_ready", sr4, 1'b1);
        step();
        check("lenerr.one_cycle", le4, 1'b0);
        check("lenerr.still_idle", v4, 1'b0);
        do_start(64'd0, 64'h0000_007F_FFFF_FF00, 96'hAAAA);
        check("lenmax.accepted", v4, 1'b1);
        check("lenmax.no_err", le4, 1'b0);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;

        // Reset mid-instance; rst also outranks a simultaneous flush and start.
        do_start(64'd256, 64'd640, 96'hBBBB);
        step(); step();
        rst = 1'b1; i_flush = 1'b1; i_start = 1'b1;
        step();
        rst = 1'b0; i_flush = 1'b0; i_start = 1'b0;
        check("midrst.valid", v4, 1'b0);
        check("midrst.phase", ph4, 3'b100);
        check("midrst.counter", cnt4, 32'd0);
        check("midrst.block", blk4, 128'd0);
        check("midrst.lane", lane4, 2'd0);
        check("midrst.last", last4, 1'b0);
        check("midrst.len_err", le4, 1'b0);
        check("midrst.start_ready", sr4, 1'b1);

        // Lane rotation for 1 and 3 workers, text=640.
        lane3_seq = '{0, 1, 2, 0, 1};
        do_start(64'd0, 64'd640, 96'hCCCC);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("lanes.w1.b%0d", k), lane1, 1'b0);
            check($sformatf("lanes.w3.b%0d", k), lane3, lane3_seq[k]);
            check($sformatf("lanes.w3.valid%0d", k), v3, 1'b1);
            step();
        end
        if (J0 == 1) begin
            check("lanes.w3.j0", lane3, 2'd2);
            step();
        end
        check("lanes.idle_after", sr3, 1'b1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
